// File: rtl/drum_pkg.sv
// Shared types and tempo constants for the drum machine run-time blocks.
package drum_pkg;

    // Run mode of the scheduler.
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        PLAY   = 2'd1,
        RECORD = 2'd2
    } mode_t;

    // Pattern geometry: eight steps per bar, indexed 7 down to 0.
    localparam int STEPS  = 8;
    localparam int STEP_W = 3;

    // Default build: four tracks, 50 MHz clock, 120 BPM sixteenths.
    localparam int          TRACKS_DEFAULT     = 4;
    localparam logic [31:0] PERIOD_DEFAULT_CYC = 32'd6_250_000;
    localparam logic [31:0] PERIOD_MIN_CYC     = 32'd1_562_500;
    localparam logic [31:0] PERIOD_MAX_CYC     = 32'd25_000_000;
    localparam logic [31:0] PERIOD_STEP_CYC    = 32'd312_500;

    // Next step period after one tempo event. The limits are checked before
    // the add/subtract, so the result never wraps around 32 bits.
    function automatic logic [31:0] next_period(
        input logic [31:0] cur,
        input logic        up,
        input logic        down,
        input logic [31:0] pmin,
        input logic [31:0] pmax,
        input logic [31:0] pstep
    );
        logic [31:0] res;
        res = cur;
        if (up && !down) begin
            res = (cur < pmin + pstep) ? pmin : cur - pstep;
        end else if (down && !up) begin
            res = (cur > pmax - pstep) ? pmax : cur + pstep;
        end
        return res;
    endfunction

endpackage

// File: rtl/step_tempo_gen.sv
// Step timing: tempo period register, phase counter, beat and step strobes.
// The period register changes immediately on a tempo event, but the phase
// counter only picks it up at the next wrap, so a running step is never cut.
module step_tempo_gen
    import drum_pkg::*;
#(
    parameter logic [31:0] PERIOD_DEFAULT = PERIOD_DEFAULT_CYC,
    parameter logic [31:0] PERIOD_MIN     = PERIOD_MIN_CYC,
    parameter logic [31:0] PERIOD_MAX     = PERIOD_MAX_CYC,
    parameter logic [31:0] PERIOD_STEP    = PERIOD_STEP_CYC
) (
    input  logic clock,
    input  logic reset,
    input  logic run,         // mode after this edge is PLAY or RECORD
    input  logic tempo_up,
    input  logic tempo_down,
    output logic beat,
    output logic step_start,  // this cycle is the first cycle of a step
    output logic step_load,   // this edge enters a run from IDLE
    output logic step_adv     // this edge wraps the phase counter
);

    logic [31:0] period;
    logic [31:0] period_active;
    logic [31:0] phase;
    logic [31:0] phase_next;
    logic [31:0] active_next;
    logic        run_q;

    // Phase advance, wrap and reload decisions for the coming edge.
    always_comb begin
        // NOTE: every output of this block gets a default before any branch,
        // otherwise an unassigned path would infer a latch.
        phase_next  = phase;
        active_next = period_active;
        step_load   = 1'b0;
        step_adv    = 1'b0;
        if (run && !run_q) begin
            phase_next  = '0;
            active_next = period;
            step_load   = 1'b1;
        end else if (run && run_q) begin
            if (phase == period_active - 32'd1) begin
                phase_next  = '0;
                active_next = period;
                step_adv    = 1'b1;
            end else begin
                phase_next = phase + 32'd1;
            end
        end
    end

    assign step_start = run_q && (phase == '0);

    // Timing registers; beat is computed from the post-edge phase so it
    // rises on the same edge as the step index changes.
    always_ff @(posedge clock) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples pre-edge values regardless of statement order.
        if (reset) begin
            run_q         <= 1'b0;
            phase         <= '0;
            period_active <= PERIOD_DEFAULT;
            period        <= PERIOD_DEFAULT;
            beat          <= 1'b0;
        end else begin
            run_q         <= run;
            phase         <= phase_next;
            period_active <= active_next;
            period        <= next_period(period, tempo_up, tempo_down,
                                         PERIOD_MIN, PERIOD_MAX, PERIOD_STEP);
            beat          <= run && (phase_next < (active_next >> 1));
        end
    end

endmodule

// File: rtl/drum_step_scheduler.sv
// Drum machine run-time controller: mode FSM, track select, step counter
// and per-track trigger lookup. Front-panel pulses are flopped once, so a
// pulse sampled at edge N is acted on at edge N+1.
module drum_step_scheduler
    import drum_pkg::*;
#(
    parameter  int          NUM_TRACKS     = TRACKS_DEFAULT,
    parameter  logic [31:0] PERIOD_DEFAULT = PERIOD_DEFAULT_CYC,
    parameter  logic [31:0] PERIOD_MIN     = PERIOD_MIN_CYC,
    parameter  logic [31:0] PERIOD_MAX     = PERIOD_MAX_CYC,
    parameter  logic [31:0] PERIOD_STEP    = PERIOD_STEP_CYC,
    localparam int          TRACK_W        = (NUM_TRACKS > 1) ? $clog2(NUM_TRACKS) : 1
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    start_stop,
    input  logic                    rec,
    input  logic                    next_track,
    input  logic                    tempo_up,
    input  logic                    tempo_down,
    input  logic [8*NUM_TRACKS-1:0] patterns,
    output logic                    beat,
    output logic [STEP_W-1:0]       step,
    output logic [NUM_TRACKS-1:0]   rec_enable,
    output logic [NUM_TRACKS-1:0]   trig,
    output logic [TRACK_W-1:0]      track_sel,
    output logic                    running
);

    localparam logic [STEP_W-1:0]  FIRST_STEP = STEP_W'(STEPS - 1);
    localparam logic [TRACK_W-1:0] LAST_TRACK = TRACK_W'(NUM_TRACKS - 1);

    logic                  ss_q;
    logic                  rec_q;
    logic                  next_q;
    logic                  up_q;
    logic                  down_q;
    mode_t                 mode_q;
    mode_t                 mode_d;
    logic                  run_d;
    logic [TRACK_W-1:0]    track_d;
    logic [NUM_TRACKS-1:0] rec_enable_d;
    logic [NUM_TRACKS-1:0] trig_d;
    logic                  step_start;
    logic                  step_load;
    logic                  step_adv;

    // Flop the front-panel pulses so all decisions use registered inputs.
    always_ff @(posedge clock) begin
        if (reset) begin
            ss_q   <= 1'b0;
            rec_q  <= 1'b0;
            next_q <= 1'b0;
            up_q   <= 1'b0;
            down_q <= 1'b0;
        end else begin
            ss_q   <= start_stop;
            rec_q  <= rec;
            next_q <= next_track;
            up_q   <= tempo_up;
            down_q <= tempo_down;
        end
    end

    // Mode state register.
    always_ff @(posedge clock) begin
        if (reset) begin
            mode_q <= IDLE;
        end else begin
            mode_q <= mode_d;
        end
    end

    // Next mode; start_stop outranks rec when both arrive together.
    always_comb begin
        mode_d = mode_q;
        case (mode_q)
            IDLE: begin
                if (ss_q)       mode_d = PLAY;
                else if (rec_q) mode_d = RECORD;
            end
            PLAY: begin
                if (ss_q)       mode_d = IDLE;
                else if (rec_q) mode_d = RECORD;
            end
            RECORD: begin
                if (ss_q)       mode_d = IDLE;
                else if (rec_q) mode_d = PLAY;
            end
            default: mode_d = IDLE;
        endcase
    end

    assign run_d = (mode_d != IDLE);

    // Track selection steps round-robin through the tracks.
    always_comb begin
        track_d = track_sel;
        if (next_q) begin
            track_d = (track_sel == LAST_TRACK) ? '0 : track_sel + TRACK_W'(1);
        end
    end

    // Only the selected track's input block may record, and only in RECORD.
    always_comb begin
        rec_enable_d = '0;
        if (mode_d == RECORD) begin
            rec_enable_d[track_d] = 1'b1;
        end
    end

    // At a step start each track fires if its pattern bit for this step is set.
    always_comb begin
        trig_d = '0;
        if (step_start) begin
            for (int t = 0; t < NUM_TRACKS; t++) begin
                trig_d[t] = patterns[8*t + int'(step)];
            end
        end
    end

    // Registered mode-related outputs and the track selection.
    always_ff @(posedge clock) begin
        if (reset) begin
            track_sel  <= '0;
            running    <= 1'b0;
            rec_enable <= '0;
        end else begin
            track_sel  <= track_d;
            running    <= run_d;
            rec_enable <= rec_enable_d;
        end
    end

    // Step counter runs 7 down to 0 and wraps; triggers lag step start by one.
    always_ff @(posedge clock) begin
        if (reset) begin
            step <= FIRST_STEP;
            trig <= '0;
        end else begin
            trig <= trig_d;
            if (step_load) begin
                step <= FIRST_STEP;
            end else if (step_adv) begin
                step <= step - STEP_W'(1);
            end
        end
    end

    step_tempo_gen #(
        .PERIOD_DEFAULT (PERIOD_DEFAULT),
        .PERIOD_MIN     (PERIOD_MIN),
        .PERIOD_MAX     (PERIOD_MAX),
        .PERIOD_STEP    (PERIOD_STEP)
    ) u_tempo (
        .clock      (clock),
        .reset      (reset),
        .run        (run_d),
        .tempo_up   (up_q),
        .tempo_down (down_q),
        .beat       (beat),
        .step_start (step_start),
        .step_load  (step_load),
        .step_adv   (step_adv)
    );

endmodule

// File: tb/tb_drum_step_scheduler.sv
// Directed bench for drum_step_scheduler with a short tempo (period 8,
// clamps 4..16, step 2). Expected values are hand-derived cycle positions.
module tb_drum_step_scheduler;

    localparam int NT = 4;

    logic            clock = 1'b0;
    logic            reset;
    logic            start_stop;
    logic            rec;
    logic            next_track;
    logic            tempo_up;
    logic            tempo_down;
    logic [8*NT-1:0] patterns;
    logic            beat;
    logic [2:0]      step;
    logic [NT-1:0]   rec_enable;
    logic [NT-1:0]   trig;
    logic [1:0]      track_sel;
    logic            running;

    int checks   = 0;
    int failures = 0;

    logic [2:0]    es;
    logic          eb;
    logic [NT-1:0] et;
    int            len;
    int            hi;

    drum_step_scheduler #(
        .NUM_TRACKS     (NT),
        .PERIOD_DEFAULT (32'd8),
        .PERIOD_MIN     (32'd4),
        .PERIOD_MAX     (32'd16),
        .PERIOD_STEP    (32'd2)
    ) dut (
        .clock      (clock),
        .reset      (reset),
        .start_stop (start_stop),
        .rec        (rec),
        .next_track (next_track),
        .tempo_up   (tempo_up),
        .tempo_down (tempo_down),
        .patterns   (patterns),
        .beat       (beat),
        .step       (step),
        .rec_enable (rec_enable),
        .trig       (trig),
        .track_sel  (track_sel),
        .running    (running)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, actual, expected);
        end
    endtask

    // Advance one clock and settle just after the edge.
    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic ticks(input int n);
        repeat (n) tick();
    endtask

    task automatic do_reset();
        reset      = 1'b1;
        start_stop = 1'b0;
        rec        = 1'b0;
        next_track = 1'b0;
        tempo_up   = 1'b0;
        tempo_down = 1'b0;
        ticks(2);
        reset = 1'b0;
        tick();
    endtask

    task automatic pulse_start();
        start_stop = 1'b1;
        tick();
        start_stop = 1'b0;
    endtask

    // Syncs to the next step change, then returns the length of that step
    // and the number of its cycles with beat high.
    task automatic measure(input string tag, output int n_len, output int n_hi);
        logic [2:0] s0;
        int         n;
        s0 = step;
        n  = 0;
        while (step == s0 && n < 200) begin
            tick();
            n++;
        end
        check({tag, "_sync"}, 32'(step != s0), 32'd1);
        s0    = step;
        n_len = 0;
        n_hi  = 0;
        while (step == s0 && n_len < 200) begin
            if (beat) n_hi++;
            n_len++;
            tick();
        end
        check({tag, "_end"}, 32'(step != s0), 32'd1);
    endtask

    function automatic logic [NT-1:0] trig_for(input logic [2:0] s);
        logic [NT-1:0] r;
        for (int t = 0; t < NT; t++) r[t] = patterns[8*t + int'(s)];
        return r;
    endfunction

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        // track3 .. track0
        patterns = {8'hA5, 8'h0F, 8'h00, 8'b1000_0001};

        // ---- reset state ----
        reset      = 1'b1;
        start_stop = 1'b0;
        rec        = 1'b0;
        next_track = 1'b0;
        tempo_up   = 1'b0;
        tempo_down = 1'b0;
        ticks(3);
        check("reset_out", 32'({running, beat, step, trig, rec_enable, track_sel}),
              32'({1'b0, 1'b0, 3'd7, 4'b0000, 4'b0000, 2'd0}));
        reset = 1'b0;
        tick();
        check("idle_out", 32'({running, beat, step, trig, rec_enable}),
              32'({1'b0, 1'b0, 3'd7, 4'b0000, 4'b0000}));

        // ---- play: step sequence, beat duty, triggers ----
        pulse_start();
        for (int c = 0; c < 76; c++) begin
            tick();
            es = 3'(7 - (c / 8) % 8);
            eb = (c % 8) < 4;
            et = (c % 8 == 1) ? trig_for(es) : '0;
            check($sformatf("play_c%0d", c), 32'({running, step, beat, trig}),
                  32'({1'b1, es, eb, et}));
        end

        // ---- start_stop and rec together in PLAY: stop, step frozen ----
        start_stop = 1'b1;
        rec        = 1'b1;
        tick();
        start_stop = 1'b0;
        rec        = 1'b0;
        tick();
        for (int c = 0; c < 12; c++) begin
            check($sformatf("stopped_c%0d", c), 32'({running, beat, step, trig, rec_enable}),
                  32'({1'b0, 1'b0, 3'd6, 4'b0000, 4'b0000}));
            tick();
        end
        pulse_start();
        tick();
        check("restart", 32'({running, beat, step, trig}), 32'({1'b1, 1'b1, 3'd7, 4'b0000}));
        tick();
        check("restart_trig", 32'(trig), 32'(4'b1001));

        // ---- record, track select, back to play ----
        do_reset();
        rec = 1'b1;
        tick();
        rec = 1'b0;
        tick();                                       // j=0
        check("rec_entry", 32'({running, rec_enable, track_sel, step}),
              32'({1'b1, 4'b0001, 2'd0, 3'd7}));
        next_track = 1'b1;
        ticks(5);
        next_track = 1'b0;
        tick();                                       // j=6
        check("rec_track", 32'({rec_enable, track_sel, step}), 32'({4'b0010, 2'd1, 3'd7}));
        ticks(14);                                    // j=20
        rec = 1'b1;
        tick();
        rec = 1'b0;
        tick();                                       // j=22
        check("rec_exit", 32'({running, rec_enable, track_sel, step, beat}),
              32'({1'b1, 4'b0000, 2'd1, 3'd5, 1'b0}));
        ticks(2);                                     // j=24
        check("play_cont", 32'({step, beat}), 32'({3'd4, 1'b1}));

        // ---- tempo: clamp at minimum, applied only at the next wrap ----
        do_reset();
        pulse_start();
        tick();                                       // j=0
        tempo_up = 1'b1;
        ticks(3);
        tempo_up = 1'b0;                              // j=3
        ticks(4);                                     // j=7
        check("tempo_hold", 32'({step, beat}), 32'({3'd7, 1'b0}));
        for (int j = 8; j < 20; j++) begin
            tick();
            es = 3'(6 - (j - 8) / 4);
            eb = ((j - 8) % 4) < 2;
            check($sformatf("fast_j%0d", j), 32'({step, beat}), 32'({es, eb}));
        end

        // ---- tempo: clamp at maximum ----
        tempo_down = 1'b1;
        ticks(8);
        tempo_down = 1'b0;
        measure("slow_a", len, hi);
        measure("slow_b", len, hi);
        check("slow_len", 32'(len), 32'd16);
        check("slow_beat", 32'(hi), 32'd8);

        // ---- tempo: up and down together leave the period alone ----
        tempo_up   = 1'b1;
        tempo_down = 1'b1;
        tick();
        tempo_up   = 1'b0;
        tempo_down = 1'b0;
        measure("both_a", len, hi);
        measure("both_b", len, hi);
        check("both_len", 32'(len), 32'd16);

        // ---- reset in the middle of RECORD ----
        do_reset();
        next_track = 1'b1;
        ticks(2);
        next_track = 1'b0;
        ticks(2);
        rec = 1'b1;
        tick();
        rec = 1'b0;
        tick();                                       // j=0
        check("rec2_entry", 32'({rec_enable, track_sel}), 32'({4'b0100, 2'd2}));
        ticks(29);                                    // j=29
        tempo_up = 1'b1;
        tick();
        tempo_up = 1'b0;
        ticks(4);                                     // j=34
        check("rec2_step3", 32'({running, step, rec_enable}), 32'({1'b1, 3'd3, 4'b0100}));
        reset = 1'b1;
        tick();
        check("midrst", 32'({running, beat, step, trig, rec_enable, track_sel}),
              32'({1'b0, 1'b0, 3'd7, 4'b0000, 4'b0000, 2'd0}));
        reset = 1'b0;
        tick();
        check("midrst_idle", 32'({running, beat, step}), 32'({1'b0, 1'b0, 3'd7}));
        pulse_start();
        tick();
        check("midrst_start", 32'({running, beat, step}), 32'({1'b1, 1'b1, 3'd7}));
        measure("midrst_per", len, hi);
        check("midrst_len", 32'(len), 32'd8);
        check("midrst_beat", 32'(hi), 32'd4);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
